// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - instruction control sequencer: fetch/exec/memory-wait/halt FSM
module control_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] decoded_id,
    input  logic       decoded_valid,
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    input  logic       mem_ready,
    output logic [6:0] ID,
    output logic       take,
    output logic       MODE,
    output logic       fetch_enable,
    output logic       busy,
    output logic       fault
);
    localparam logic [2:0] ST_RST      = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_EXEC     = 3'd2;
    localparam logic [2:0] ST_MEM_WAIT = 3'd3;
    localparam logic [2:0] ST_HALT     = 3'd4;

    localparam logic [6:0] ID_RST    = 7'd100;
    localparam logic [6:0] ID_BRANCH = 7'd36;
    localparam logic [6:0] ID_SVC    = 7'd72;
    localparam logic [6:0] ID_RET    = 7'd74;
    localparam logic [6:0] ID_HALT   = 7'd75;
    localparam logic [3:0] TIMEOUT   = 4'(MEM_TIMEOUT);

    logic [2:0] state_q, state_d;
    logic [6:0] ir_q, ir_d;
    logic [3:0] cnt_q, cnt_d;
    logic       take_q, take_d;
    logic       mode_q, mode_d;
    logic       fetch_enable_q, fetch_enable_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;

    logic       is_mem;
    logic       cond_base;
    logic       cond_true;
    logic [3:0] cnt_inc;
    logic       timeout_hit;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags;
    assign is_mem = ((ir_q >= 7'd39) && (ir_q <= 7'd55)) ||
                    (ir_q == 7'd67) || (ir_q == 7'd68) || (ir_q == 7'd71);
    assign cnt_inc     = cnt_q + 4'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT);

    // Conditions come in true/inverted pairs; cond[0] selects the inverted half.
    always_comb begin
        case (cond[3:1])
            3'd0:    cond_base = z_f;
            3'd1:    cond_base = c_f;
            3'd2:    cond_base = n_f;
            3'd3:    cond_base = v_f;
            3'd4:    cond_base = c_f & ~z_f;
            3'd5:    cond_base = (n_f == v_f);
            3'd6:    cond_base = ~z_f & (n_f == v_f);
            default: cond_base = 1'b1;
        endcase
        cond_true = (cond == 4'd15) ? 1'b0 : (cond_base ^ cond[0]);
    end

    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        cnt_d          = 4'd0;
        take_d         = take_q;
        mode_d         = mode_q;
        fetch_enable_d = 1'b0;
        fault_d        = fault_q;
        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                if (decoded_valid) begin
                    ir_d    = decoded_id;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ir_q == ID_BRANCH) take_d = cond_true;
                if ((ir_q == ID_SVC) && !mode_q)      mode_d = 1'b1;
                else if ((ir_q == ID_RET) && mode_q)  mode_d = 1'b0;
                if (is_mem) begin
                    state_d = ST_MEM_WAIT;
                end else if (ir_q == ID_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    fetch_enable_d = 1'b1;
                    state_d        = ST_FETCH;
                end
            end
            ST_MEM_WAIT: begin
                cnt_d = cnt_inc;
                // A completion arriving on the timeout cycle still counts as success.
                if (mem_ready) begin
                    fetch_enable_d = 1'b1;
                    state_d        = ST_FETCH;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
        busy_d = (state_d != ST_FETCH);
    end

    always_comb begin
        case (state_q)
            ST_FETCH:    ID = 7'd0;
            ST_EXEC:     ID = ir_q;
            ST_MEM_WAIT: ID = (timeout_hit && !mem_ready) ? 7'd0 : ir_q;
            ST_HALT:     ID = ID_HALT;
            default:     ID = ID_RST;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RST;
            ir_q           <= 7'd0;
            cnt_q          <= 4'd0;
            take_q         <= 1'b0;
            mode_q         <= 1'b1;
            fetch_enable_q <= 1'b0;
            busy_q         <= 1'b1;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            cnt_q          <= cnt_d;
            take_q         <= take_d;
            mode_q         <= mode_d;
            fetch_enable_q <= fetch_enable_d;
            busy_q         <= busy_d;
            fault_q        <= fault_d;
        end
    end

    assign take         = take_q;
    assign MODE         = mode_q;
    assign fetch_enable = fetch_enable_q;
    assign busy         = busy_q;
    assign fault        = fault_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;
    localparam int TO = 15;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] decoded_id;
    logic       decoded_valid;
    logic [3:0] cond;
    logic [3:0] flags;
    logic       mem_ready;
    logic [6:0] ID;
    logic       take, MODE, fetch_enable, busy, fault;

    control_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .decoded_id(decoded_id), .decoded_valid(decoded_valid),
        .cond(cond), .flags(flags), .mem_ready(mem_ready), .ID(ID), .take(take), .MODE(MODE),
        .fetch_enable(fetch_enable), .busy(busy), .fault(fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       valid;
        logic [6:0] id;
        logic [3:0] cd;
        logic [3:0] fl;
        logic       rdy;
        logic [6:0] e_id;
        logic       e_busy;
        logic       e_fe;
        logic       e_take;
        logic       e_mode;
        logic       e_fault;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Transaction-level reference state
    logic m_mode, m_take, m_fault, m_pend;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_is_mem(input logic [6:0] id);
        return id inside {[7'd39:7'd55], 7'd67, 7'd68, 7'd71};
    endfunction

    task automatic push(input logic v, input logic [6:0] id, input logic [3:0] cd, input logic [3:0] fl,
                        input logic rdy, input logic [6:0] eid, input logic eb);
        vec_t r;
        r.valid = v; r.id = id; r.cd = cd; r.fl = fl; r.rdy = rdy;
        r.e_id = eid; r.e_busy = eb; r.e_fe = m_pend;
        r.e_take = m_take; r.e_mode = m_mode; r.e_fault = m_fault;
        m_pend = 1'b0;
        vq.push_back(r);
    endtask

    task automatic gen_idle(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 7'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 7'd0, 1'b0);
    endtask

    // ready_at: MEM_WAIT cycle (1-based) on which mem_ready rises; 0 = never
    task automatic gen_txn(input logic [6:0] id, input logic [3:0] cd, input logic [3:0] fl,
                           input int ready_at, input int gap);
        bit done;
        gen_idle(gap);
        push(1'b1, id, cd, fl, 1'($urandom), 7'd0, 1'b0);
        push(1'($urandom), 7'($urandom), cd, fl, 1'($urandom), id, 1'b1);
        if (id == 7'd36) m_take = ref_cond(cd, fl);
        if (id == 7'd72) m_mode = 1'b1;
        if (id == 7'd74) m_mode = 1'b0;
        if (id == 7'd75) begin
            for (int i = 0; i < 20; i++)
                push(1'b1, 7'($urandom), cd, fl, 1'($urandom), 7'd75, 1'b1);
        end else if (ref_is_mem(id)) begin
            done = 0;
            for (int k = 1; k <= TO && !done; k++) begin
                if (k == ready_at) begin
                    push(1'($urandom), 7'($urandom), cd, fl, 1'b1, id, 1'b1);
                    m_pend = 1'b1;
                    done = 1;
                end else if (k == TO) begin
                    push(1'($urandom), 7'($urandom), cd, fl, 1'b0, 7'd0, 1'b1);
                    m_fault = 1'b1;
                end else begin
                    push(1'($urandom), 7'($urandom), cd, fl, 1'b0, id, 1'b1);
                end
            end
        end else begin
            m_pend = 1'b1;
        end
    endtask

    task automatic run_vectors();
        vec_t r;
        while (vq.size() > 0) begin
            r = vq.pop_front();
            decoded_valid = r.valid; decoded_id = r.id; cond = r.cd; flags = r.fl; mem_ready = r.rdy;
            #2;
            check("ID", ID, r.e_id);
            check("busy", 7'(busy), 7'(r.e_busy));
            check("fetch_enable", 7'(fetch_enable), 7'(r.e_fe));
            check("take", 7'(take), 7'(r.e_take));
            check("MODE", 7'(MODE), 7'(r.e_mode));
            check("fault", 7'(fault), 7'(r.e_fault));
            @(posedge clock); #1; cyc++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ID"}, ID, 7'd100);
        check({tag, "_busy"}, 7'(busy), 7'd1);
        check({tag, "_MODE"}, 7'(MODE), 7'd1);
        check({tag, "_take"}, 7'(take), 7'd0);
        check({tag, "_fe"}, 7'(fetch_enable), 7'd0);
        check({tag, "_fault"}, 7'(fault), 7'd0);
    endtask

    // Called at posedge+1 with reset low; ends in FETCH at posedge+1.
    task automatic release_reset();
        reset = 1'b1;
        #2;
        check("rst_cycle_ID", ID, 7'd100);
        check("rst_cycle_busy", 7'(busy), 7'd1);
        @(posedge clock); #1; cyc++;
        m_mode = 1'b1; m_take = 1'b0; m_fault = 1'b0; m_pend = 1'b0;
    endtask

    task automatic reset_now(input string tag);
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        @(posedge clock); #1; cyc++;
        check_reset_values({tag, "_held"});
    endtask

    initial begin
        logic [6:0] rid;
        int sel;
        reset = 1'b0; decoded_valid = 1'b0; decoded_id = 7'd0; cond = 4'd0; flags = 4'd0; mem_ready = 1'b0;
        m_mode = 1'b1; m_take = 1'b0; m_fault = 1'b0; m_pend = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("in_reset");
        release_reset();

        // Directed scenarios
        gen_txn(7'd4, 4'd0, 4'd0, 0, 1);
        gen_txn(7'd44, 4'd0, 4'd0, 3, 0);
        gen_txn(7'd50, 4'd0, 4'd0, TO, 1);
        gen_txn(7'd38, 4'd0, 4'd0, 0, 0);
        gen_txn(7'd56, 4'd0, 4'd0, 0, 0);
        gen_txn(7'd67, 4'd0, 4'd0, 1, 0);
        gen_txn(7'd71, 4'd0, 4'd0, 2, 0);
        gen_txn(7'd44, 4'd0, 4'd0, 0, 1);
        gen_txn(7'd74, 4'd0, 4'd0, 0, 1);
        gen_txn(7'd72, 4'd0, 4'd0, 0, 1);
        gen_txn(7'd74, 4'd0, 4'd0, 0, 0);
        gen_txn(7'd36, 4'd0, 4'b0100, 0, 1);
        gen_txn(7'd36, 4'd11, 4'b1000, 0, 0);
        gen_txn(7'd36, 4'd15, 4'b0100, 0, 1);
        gen_txn(7'd72, 4'd0, 4'd0, 0, 0);
        gen_idle(2);
        run_vectors();

        // Reset during EXEC of 74 with MODE=1 abandons the pending MODE change
        decoded_valid = 1'b1; decoded_id = 7'd74;
        @(posedge clock); #1; cyc++;
        decoded_valid = 1'b0;
        #1;
        check("exec74_ID", ID, 7'd74);
        check("exec74_MODE", 7'(MODE), 7'd1);
        reset_now("mid_exec");
        release_reset();

        // Randomized traffic against the transaction model
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 2) begin
                rid = 7'($urandom_range(39, 58));
                if (rid > 7'd55) rid = (rid == 7'd56) ? 7'd67 : (rid == 7'd57) ? 7'd68 : 7'd71;
            end else if (sel <= 4) rid = 7'd36;
            else if (sel == 5) rid = 7'd72;
            else if (sel == 6) rid = 7'd74;
            else begin
                rid = 7'($urandom);
                while (ref_is_mem(rid) || rid == 7'd75) rid = 7'($urandom);
            end
            gen_txn(rid, 4'($urandom), 4'($urandom), $urandom_range(0, TO), $urandom_range(0, 2));
        end
        gen_txn(7'd75, 4'd0, 4'd0, 0, 1);
        run_vectors();
        reset_now("mid_halt");
        release_reset();
        gen_txn(7'd4, 4'd0, 4'd0, 0, 0);
        gen_idle(1);
        run_vectors();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
